l2_cache_control: RTL
=====================

# l2_cache_control

- Control FSM for the unified, 2-way set-associative L2 cache.
- Sits on the L2 side of the I/D-cache arbiter:
  - accepts `L2_read`/`L2_write` from the arbiter and answers with a one-cycle `L2_resp`;
  - drives the L2 datapath (tag/data/valid/dirty/LRU arrays);
  - issues line writebacks and fills to physical memory.
- Keeps saturating hit/miss counters for performance debug.

## Interface
Parameters:
- `CNT_WIDTH`, 16, width of `hit_count` and `miss_count`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous reset, active low.
- `L2_read`  in  1  read request from the arbiter; held until `L2_resp`.
- `L2_write`  in  1  write request from the arbiter; held until `L2_resp`; mutually exclusive with `L2_read`.
- `L2_resp`  out  1  request complete; one-cycle pulse.
- `hit0`, `hit1`  in  1 each  datapath tag match AND valid for way 0 / way 1 at the request index.
- `lru`  in  1  LRU way at the request index; this is the victim.
- `victim_valid`, `victim_dirty`  in  1 each  valid/dirty bits of way `lru`.
- `pmem_resp`  in  1  physical memory done.
- `pmem_read`, `pmem_write`  out  1 each  physical memory strobes; held until `pmem_resp`.
- `way_sel`  out  1  way targeted by the `load_*` strobes.
- `load_data`, `load_tag`, `load_valid`, `load_dirty`, `load_lru`  out  1 each  array write enables.
- `dirty_in`  out  1  value written with `load_dirty`.
- `lru_in`  out  1  value written with `load_lru`.
- `data_src`  out  1  data array input: 0 = arbiter write data (word-merged), 1 = pmem line.
- `pmem_addr_sel`  out  1  pmem address: 0 = request line address, 1 = victim {tag, index}.
- `hit_count`, `miss_count`  out  `CNT_WIDTH` each  performance counters.

## Operation
The FSM has three states; reset state is CHECK.
- **CHECK**
  - No request: all strobes low; stay in CHECK.
  - Request and (`hit0` | `hit1`):
    - assert `L2_resp` the same cycle;
    - `way_sel` = hit way (`hit0` wins if both are set; a tag duplicate is a datapath error);
    - `load_lru` = 1 and `lru_in` = ~hit way;
    - on a write, also `load_data` = 1, `data_src` = 0, `load_dirty` = 1, `dirty_in` = 1;
    - stay in CHECK.
  - Request and miss: go to WRITEBACK if `victim_valid` & `victim_dirty`, otherwise go to ALLOCATE.
- **WRITEBACK**
  - `pmem_write` = 1, `pmem_addr_sel` = 1, `way_sel` = `lru`.
  - On `pmem_resp`, go to ALLOCATE.
- **ALLOCATE**
  - `pmem_read` = 1, `pmem_addr_sel` = 0, `way_sel` = `lru`.
  - On `pmem_resp`, in the same cycle: `load_data` (with `data_src` = 1), `load_tag`, `load_valid`, and `load_dirty` with `dirty_in` = 0. Then go to CHECK.
  - CHECK then hits and completes the request; a write merges there and sets dirty.
- `miss_pending` flag:
  - set on the CHECK→WRITEBACK/ALLOCATE transition;
  - cleared on `L2_resp`.
- Counters:
  - `miss_count` increments on each miss transition;
  - `hit_count` increments on `L2_resp` when `miss_pending` = 0;
  - both saturate at all-ones and never wrap.
- Once a miss sequence has started, it always completes. Deasserting the request mid-sequence does not abort it; the line is still filled.

## Timing
- Reset (async, `reset_n` = 0):
  - state = CHECK, `miss_pending` = 0, both counters = 0;
  - every output = 0 immediately, independent of `clk`.
- `L2_resp` is Mealy, combinational in CHECK from the request and hit inputs. The arbiter changes its request in the cycle after `L2_resp`, and that new request is evaluated fresh in CHECK.
- Latency:
  - hit: 1 cycle;
  - clean miss: ALLOCATE (≥1 cycle, plus pmem wait), then 1 CHECK cycle;
  - dirty miss: adds WRITEBACK before ALLOCATE.
- `pmem_read`/`pmem_write` are never asserted together, and are never asserted in CHECK.
- If `pmem_resp` arrives in the first cycle of WRITEBACK/ALLOCATE, the transition happens on that edge.
- Reset asserted during WRITEBACK/ALLOCATE: the pmem strobe drops asynchronously and no array load occurs.
- A counter at saturation with a simultaneous increment condition holds its value.

## Structure
- Add to `lc3b_types`:
  - `l2_state_t` enum {CHECK, WRITEBACK, ALLOCATE};
  - `lc3b_l2_way` (1-bit typedef);
  - constants `L2_DSRC_ARB` = 0, `L2_DSRC_PMEM` = 1.
- One sub-module, `sat_counter #(WIDTH)`: inputs `clk`, `reset_n`, `inc`; output `count`. Instantiate it twice.
- Next-state logic, output logic and state register are separate blocks.

## Test plan
1. Reset mid-ALLOCATE with `pmem_read` = 1: pull `reset_n` low → `pmem_read` = 0 before the next edge; state = CHECK; counters = 0.
2. Read with `hit1` = 1: `L2_resp` = 1 the same cycle, `way_sel` = 1, `lru_in` = 0, `load_data` = 0; `hit_count` 0→1.
3. Write with `hit0` = 1: `L2_resp`, `load_data`, `load_dirty` and `dirty_in` all = 1; `data_src` = 0; `lru_in` = 1.
4. Read miss with a clean victim (`lru` = 1), `pmem_resp` after 3 cycles:
   - ALLOCATE for 3 cycles; fill loads into way 1;
   - then CHECK with `hit1` → `L2_resp`;
   - `miss_count` = 1, `hit_count` unchanged.
5. Write miss with a dirty victim:
   - `pmem_write` with `pmem_addr_sel` = 1 until `pmem_resp`;
   - then `pmem_read` with `pmem_addr_sel` = 0;
   - then a write hit that sets dirty;
   - never both pmem strobes at once.
6. Preload `hit_count` near saturation (`CNT_WIDTH` = 4, 15 hits), then one more hit → count stays at 15.

Source files
------------

// File: rtl/l2_cache_control_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types (L2 cache additions)
// Purpose : shared types and constants for the L2 cache control path.
//   l2_state_t   - control FSM states (CHECK / WRITEBACK / ALLOCATE)
//   lc3b_l2_way  - one-bit way index for the 2-way set-associative L2
//   L2_DSRC_*    - encodings of the data array input mux select
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } l2_state_t;

  typedef logic lc3b_l2_way;

  localparam logic L2_DSRC_ARB  = 1'b0;
  localparam logic L2_DSRC_PMEM = 1'b1;

endpackage

// File: rtl/l2_cache_control_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Purpose : saturating up-counter used for the L2 hit/miss statistics.
// Ports   :
//   clk     - system clock
//   reset_n - asynchronous reset, active low; clears the count
//   inc     - increment request for this cycle
//   count   - current value; sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on request, but hold once every bit is set so debug
  // statistics never roll over to a misleadingly small number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// ---------------------------------------------------------------------------
// l2_cache_control
// Purpose : control FSM for the unified 2-way set-associative L2 cache.
//           Answers arbiter requests, drives the L2 array write enables and
//           sequences victim writebacks and line fills to physical memory.
// Ports   :
//   clk, reset_n              - clock, asynchronous active-low reset
//   L2_read, L2_write         - arbiter request (held until L2_resp)
//   L2_resp                   - one-cycle completion pulse (Mealy, in CHECK)
//   hit0, hit1                - per-way tag match & valid
//   lru                       - victim way at the request index
//   victim_valid/dirty        - state bits of the victim way
//   pmem_resp                 - physical memory done
//   pmem_read, pmem_write     - physical memory strobes
//   way_sel                   - way targeted by the load_* strobes
//   load_data/tag/valid/dirty/lru, dirty_in, lru_in - array write controls
//   data_src                  - 0 arbiter write data, 1 pmem line
//   pmem_addr_sel             - 0 request line address, 1 victim address
//   hit_count, miss_count     - saturating performance counters
// ---------------------------------------------------------------------------
module l2_cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 L2_read,
  input  logic                 L2_write,
  output logic                 L2_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 lru,
  input  logic                 victim_valid,
  input  logic                 victim_dirty,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 way_sel,
  output logic                 load_data,
  output logic                 load_tag,
  output logic                 load_valid,
  output logic                 load_dirty,
  output logic                 load_lru,
  output logic                 dirty_in,
  output logic                 lru_in,
  output logic                 data_src,
  output logic                 pmem_addr_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  l2_state_t  r_state;
  l2_state_t  w_nextState;
  logic       r_missPending;
  logic       w_request;
  logic       w_hit;
  lc3b_l2_way w_hitWay;
  logic       w_missStart;
  logic       w_hitInc;

  assign w_request   = L2_read | L2_write;
  assign w_hit       = hit0 | hit1;
  // Way 0 takes priority; both ways matching is a datapath fault anyway.
  assign w_hitWay    = hit0 ? 1'b0 : 1'b1;
  assign w_missStart = (r_state == CHECK) && w_request && !w_hit;
  assign w_hitInc    = L2_resp && !r_missPending;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CHECK;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A started miss always runs to the fill, even if the
  // arbiter drops its request, so WRITEBACK/ALLOCATE ignore L2_read/L2_write.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CHECK: begin
        if (w_missStart) begin
          w_nextState = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          w_nextState = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          w_nextState = CHECK;
        end
      end
      default: w_nextState = CHECK;
    endcase
  end

  // Output logic. Everything is forced low while reset_n is asserted so the
  // pmem strobes and L2_resp drop immediately, without waiting for a clock.
  always_comb begin
    L2_resp       = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    load_lru      = 1'b0;
    dirty_in      = 1'b0;
    lru_in        = 1'b0;
    data_src      = L2_DSRC_ARB;
    pmem_addr_sel = 1'b0;
    if (reset_n) begin
      case (r_state)
        CHECK: begin
          if (w_request && w_hit) begin
            L2_resp  = 1'b1;
            way_sel  = w_hitWay;
            load_lru = 1'b1;
            lru_in   = ~w_hitWay;
            if (L2_write) begin
              load_data  = 1'b1;
              data_src   = L2_DSRC_ARB;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = lru;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = lru;
          data_src  = L2_DSRC_PMEM;
          // The fill lands in the cycle memory answers; the line is clean
          // until CHECK merges a pending write into it.
          if (pmem_resp) begin
            load_data  = 1'b1;
            load_tag   = 1'b1;
            load_valid = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Remembers that the request now being served started as a miss, so its
  // final CHECK-cycle response is not counted as a hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_missPending <= 1'b0;
    end else if (w_missStart) begin
      r_missPending <= 1'b1;
    end else if (L2_resp) begin
      r_missPending <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hitCounter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_hitInc),
    .count   (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_missCounter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_missStart),
    .count   (miss_count)
  );

endmodule
